// File: rtl/l1d_mem_rsp_model.sv
// Downstream memory responder for the L1D environment: accepts line fills, returns
// line data after a (jittered) latency in order or out of order, and absorbs evictions.
module l1d_mem_rsp_model #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int ID_W     = 4,
    parameter int DEPTH    = 8,
    parameter int IDX_W    = 6,
    parameter int LATENCY  = 4,
    parameter int JITTER   = 0,
    parameter int RSP_MODE = 0,
    parameter int TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       downstream_req_vld,
    output logic                       downstream_req_rdy,
    input  logic [ADDR_W-1:0]          downstream_req_pld,
    input  logic [ID_W-1:0]            downstream_req_id,
    output logic                       downstream_rsp_vld,
    input  logic                       downstream_rsp_rdy,
    output logic [LINE_W-1:0]          downstream_rsp_pld,
    output logic [ID_W-1:0]            downstream_rsp_id,
    input  logic                       downstream_evict_vld,
    input  logic [ADDR_W+LINE_W-1:0]   downstream_evict_pld,
    output logic                       downstream_evict_rdy,
    output logic [$clog2(DEPTH):0]     outstanding_cnt,
    output logic                       err_dup_id,
    output logic                       err_timeout
);
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int LA_W   = ADDR_W - OFF;
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int CD_W   = $clog2(LATENCY + 4) + 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int WORDS  = LINE_W / 32;
    localparam int LINES  = 2 ** IDX_W;

    // Every channel transfers on a cycle where vld & rdy are both high; a presented
    // response holds vld, pld and id unchanged until that transfer happens.

    logic                 active;
    logic [DEPTH-1:0]     slot_vld;
    logic [ID_W-1:0]      slot_id   [DEPTH];
    logic [LA_W-1:0]      slot_line [DEPTH];
    logic [CD_W-1:0]      slot_cd   [DEPTH];
    logic [SLOT_W-1:0]    slot_age  [DEPTH];
    logic [LINE_W-1:0]    store     [LINES];
    logic [LINES-1:0]     written;
    logic [CNT_W-1:0]     cnt;
    logic                 rsp_vld_q;
    logic [LINE_W-1:0]    rsp_pld_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [SLOT_W-1:0]    rsp_slot;
    logic [TO_W-1:0]      stall_cnt;

    logic                 req_rdy;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 evict_fire;
    logic                 free_found;
    logic [SLOT_W-1:0]    free_slot;
    logic                 dup_hit;
    logic                 sel_ok;
    logic                 sel_found;
    logic                 sel_fire;
    logic [SLOT_W-1:0]    sel_slot;
    logic [SLOT_W-1:0]    tgt_age;
    logic [LA_W-1:0]      sel_line;
    logic [IDX_W-1:0]     sel_idx;
    logic [ADDR_W-1:0]    aligned_addr;
    logic [31:0]          fill_word;
    logic [LINE_W-1:0]    sel_data;
    logic [IDX_W-1:0]     evict_idx;
    logic [LINE_W-1:0]    evict_data;
    logic [CD_W-1:0]      new_cd;
    logic [SLOT_W-1:0]    new_age;
    logic [SLOT_W-1:0]    ret_age;

    assign req_rdy    = active && (cnt < CNT_W'(DEPTH));
    assign req_fire   = downstream_req_vld && req_rdy && free_found;
    assign rsp_fire   = rsp_vld_q && downstream_rsp_rdy;
    assign evict_fire = downstream_evict_vld && active;
    assign evict_idx  = downstream_evict_pld[LINE_W+OFF +: IDX_W];
    assign evict_data = downstream_evict_pld[LINE_W-1:0];

    assign new_cd  = CD_W'(LATENCY) + ((JITTER != 0) ? CD_W'(downstream_req_pld[OFF +: 2]) : '0);
    assign new_age = SLOT_W'(cnt - CNT_W'(rsp_fire));
    assign ret_age = slot_age[rsp_slot];

    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        dup_hit    = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i);
            end
            if (slot_vld[i] && (slot_id[i] == downstream_req_id)) dup_hit = 1'b1;
        end
    end

    // The presented slot is always the oldest in strict mode, so the next candidate
    // during a completing handshake is the one at age 1.
    always_comb begin
        sel_ok    = !rsp_vld_q || rsp_fire;
        tgt_age   = rsp_vld_q ? SLOT_W'(1) : '0;
        sel_found = 1'b0;
        sel_slot  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_vld[i] && (slot_cd[i] == '0) &&
                !(rsp_vld_q && (rsp_slot == SLOT_W'(i))) &&
                ((RSP_MODE != 0) || (slot_age[i] == tgt_age))) begin
                sel_found = 1'b1;
                sel_slot  = SLOT_W'(i);
            end
        end
    end
    assign sel_fire = sel_ok && sel_found;

    always_comb begin
        sel_line     = slot_line[sel_slot];
        sel_idx      = sel_line[IDX_W-1:0];
        aligned_addr = {sel_line, {OFF{1'b0}}};
        fill_word    = 32'(aligned_addr);
        if (evict_fire && (evict_idx == sel_idx)) sel_data = evict_data;
        else if (written[sel_idx])                sel_data = store[sel_idx];
        else                                      sel_data = {WORDS{fill_word}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active <= 1'b0;
        else        active <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_id[i]   <= '0;
                slot_line[i] <= '0;
                slot_cd[i]   <= '0;
                slot_age[i]  <= '0;
            end
        end else begin
            cnt <= cnt + CNT_W'(req_fire) - CNT_W'(rsp_fire);
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_vld[i] && (slot_cd[i] != '0)) slot_cd[i] <= slot_cd[i] - CD_W'(1);
                if (slot_vld[i] && rsp_fire && (slot_age[i] > ret_age))
                    slot_age[i] <= slot_age[i] - SLOT_W'(1);
                if (rsp_fire && (rsp_slot == SLOT_W'(i))) slot_vld[i] <= 1'b0;
                if (req_fire && (free_slot == SLOT_W'(i))) begin
                    slot_vld[i]  <= 1'b1;
                    slot_id[i]   <= downstream_req_id;
                    slot_line[i] <= downstream_req_pld[ADDR_W-1:OFF];
                    slot_cd[i]   <= new_cd;
                    slot_age[i]  <= new_age;
                end
            end
        end
    end

    // Line data needs no reset: the written bits decide whether it is ever visible.
    always_ff @(posedge clk) begin
        if (evict_fire) store[evict_idx] <= evict_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          written <= '0;
        else if (evict_fire) written[evict_idx] <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_pld_q <= '0;
            rsp_id_q  <= '0;
            rsp_slot  <= '0;
        end else if (sel_fire) begin
            rsp_vld_q <= 1'b1;
            rsp_pld_q <= sel_data;
            rsp_id_q  <= slot_id[sel_slot];
            rsp_slot  <= sel_slot;
        end else if (rsp_fire) begin
            rsp_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
            err_dup_id  <= 1'b0;
        end else begin
            if (rsp_fire) begin
                stall_cnt <= '0;
            end else if (rsp_vld_q) begin
                if (stall_cnt != TO_W'(TIMEOUT))     stall_cnt <= stall_cnt + TO_W'(1);
                if (stall_cnt == TO_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
            end
            if (req_fire && dup_hit) err_dup_id <= 1'b1;
        end
    end

    assign downstream_req_rdy   = req_rdy;
    assign downstream_rsp_vld   = rsp_vld_q;
    assign downstream_rsp_pld   = rsp_pld_q;
    assign downstream_rsp_id    = rsp_id_q;
    assign downstream_evict_rdy = active;
    assign outstanding_cnt      = cnt;
endmodule

// File: tb/tb_l1d_mem_rsp_model.sv
// Directed bench for l1d_mem_rsp_model: instance 0 is default (in order, no jitter),
// instance 1 is out-of-order with jitter, instance 2 is in order with jitter.
module tb_l1d_mem_rsp_model;
    localparam int NI      = 3;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_vld;
    logic [31:0]  req_pld;
    logic [3:0]   req_id;
    logic         rsp_rdy;
    logic         evict_vld;
    logic [287:0] evict_pld;

    logic         req_rdy   [NI];
    logic         rsp_vld   [NI];
    logic [255:0] rsp_pld   [NI];
    logic [3:0]   rsp_id    [NI];
    logic         evict_rdy [NI];
    logic [3:0]   cnt       [NI];
    logic         err_dup   [NI];
    logic         err_to    [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        l1d_mem_rsp_model #(
            .ADDR_W(32), .LINE_W(256), .ID_W(4), .DEPTH(8), .IDX_W(6), .LATENCY(4),
            .JITTER((g >= 1) ? 1 : 0), .RSP_MODE((g == 1) ? 1 : 0), .TIMEOUT(TIMEOUT)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .downstream_req_vld(req_vld), .downstream_req_rdy(req_rdy[g]),
            .downstream_req_pld(req_pld), .downstream_req_id(req_id),
            .downstream_rsp_vld(rsp_vld[g]), .downstream_rsp_rdy(rsp_rdy),
            .downstream_rsp_pld(rsp_pld[g]), .downstream_rsp_id(rsp_id[g]),
            .downstream_evict_vld(evict_vld), .downstream_evict_pld(evict_pld),
            .downstream_evict_rdy(evict_rdy[g]),
            .outstanding_cnt(cnt[g]), .err_dup_id(err_dup[g]), .err_timeout(err_to[g])
        );
    end

    function automatic logic [255:0] rep(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_vld = 1'b0; req_pld = '0; req_id = '0;
        rsp_rdy = 1'b0; evict_vld = 1'b0; evict_pld = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_vld(input int k, input int max_cyc, output int cycles);
        cycles = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (rsp_vld[k]) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = 1'b0; req_pld = '0; req_id = '0;
        rsp_rdy = 1'b0; evict_vld = 1'b0; evict_pld = '0;
        tick();
        n_checks++; if (req_rdy[0] !== 1'b0) begin n_errors++; $display("FAIL rst_req_rdy: got %b exp 0", req_rdy[0]); end
        n_checks++; if (rsp_vld[0] !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_vld: got %b exp 0", rsp_vld[0]); end
        n_checks++; if (rsp_pld[0] !== '0) begin n_errors++; $display("FAIL rst_rsp_pld: got %h exp 0", rsp_pld[0]); end
        n_checks++; if (rsp_id[0] !== 4'd0) begin n_errors++; $display("FAIL rst_rsp_id: got %h exp 0", rsp_id[0]); end
        n_checks++; if (evict_rdy[0] !== 1'b0) begin n_errors++; $display("FAIL rst_evict_rdy: got %b exp 0", evict_rdy[0]); end
        n_checks++; if (cnt[0] !== 4'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d exp 0", cnt[0]); end
        n_checks++; if ({err_dup[0], err_to[0]} !== 2'b00) begin n_errors++; $display("FAIL rst_errs: got %b%b exp 00", err_dup[0], err_to[0]); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (req_rdy[0] !== 1'b1) begin n_errors++; $display("FAIL post_rst_req_rdy: got %b exp 1", req_rdy[0]); end
        n_checks++; if (evict_rdy[0] !== 1'b1) begin n_errors++; $display("FAIL post_rst_evict_rdy: got %b exp 1", evict_rdy[0]); end
    endtask

    task automatic test_single();
        int cyc;
        do_reset();
        rsp_rdy = 1'b1; req_vld = 1'b1; req_pld = 32'h0000_0040; req_id = 4'd3;
        tick();
        req_vld = 1'b0;
        n_checks++; if (cnt[0] !== 4'd1) begin n_errors++; $display("FAIL single_cnt_busy: got %0d exp 1", cnt[0]); end
        wait_vld(0, 20, cyc);
        n_checks++; if (cyc !== 5) begin n_errors++; $display("FAIL single_latency: got %0d exp 5", cyc); end
        n_checks++; if (rsp_id[0] !== 4'd3) begin n_errors++; $display("FAIL single_id: got %h exp 3", rsp_id[0]); end
        n_checks++; if (rsp_pld[0] !== rep(32'h40)) begin n_errors++; $display("FAIL single_pld: got %h exp %h", rsp_pld[0], rep(32'h40)); end
        tick();
        n_checks++; if ({rsp_vld[0], cnt[0]} !== 5'b0_0000) begin n_errors++; $display("FAIL single_drain: got vld %b cnt %0d exp 0 0", rsp_vld[0], cnt[0]); end
        req_vld = 1'b1; req_pld = 32'h0000_07F4; req_id = 4'd9;
        tick();
        req_vld = 1'b0;
        wait_vld(0, 20, cyc);
        n_checks++; if (rsp_pld[0] !== rep(32'h7E0)) begin n_errors++; $display("FAIL top_index_pld: got %h exp %h", rsp_pld[0], rep(32'h7E0)); end
        tick();
    endtask

    task automatic test_evict();
        int cyc;
        do_reset();
        rsp_rdy = 1'b1;
        evict_vld = 1'b1; evict_pld = {32'h40, {32{8'hA5}}};
        tick();
        evict_vld = 1'b0;
        req_vld = 1'b1; req_pld = 32'h40; req_id = 4'd1;
        tick();
        req_vld = 1'b0;
        wait_vld(0, 20, cyc);
        n_checks++; if (rsp_pld[0] !== {32{8'hA5}}) begin n_errors++; $display("FAIL evict_read_pld: got %h exp a5..a5", rsp_pld[0]); end
        tick();
        req_vld = 1'b1; req_pld = 32'h80; req_id = 4'd2;
        tick();
        req_vld = 1'b0;
        repeat (4) tick();
        evict_vld = 1'b1; evict_pld = {32'h80, rep(32'h1234_5678)};
        tick();
        evict_vld = 1'b0;
        n_checks++; if ({rsp_vld[0], rsp_id[0]} !== 5'b1_0010) begin n_errors++; $display("FAIL fwd_vld_id: got vld %b id %h exp 1 2", rsp_vld[0], rsp_id[0]); end
        n_checks++; if (rsp_pld[0] !== rep(32'h1234_5678)) begin n_errors++; $display("FAIL fwd_pld: got %h exp %h", rsp_pld[0], rep(32'h1234_5678)); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        rsp_rdy = 1'b0; req_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_pld = 32'(i * 32); req_id = 4'(i);
            n_checks++; if (req_rdy[0] !== 1'b1) begin n_errors++; $display("FAIL fill_rdy_%0d: got %b exp 1", i, req_rdy[0]); end
            tick();
        end
        req_pld = 32'h100; req_id = 4'd8;
        n_checks++; if ({req_rdy[0], cnt[0]} !== 5'b0_1000) begin n_errors++; $display("FAIL full_state: got rdy %b cnt %0d exp 0 8", req_rdy[0], cnt[0]); end
        repeat (4) tick();
        n_checks++; if (cnt[0] !== 4'd8) begin n_errors++; $display("FAIL full_hold_cnt: got %0d exp 8", cnt[0]); end
        n_checks++; if ({rsp_vld[0], rsp_id[0]} !== 5'b1_0000) begin n_errors++; $display("FAIL full_head: got vld %b id %h exp 1 0", rsp_vld[0], rsp_id[0]); end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        n_checks++; if ({req_rdy[0], cnt[0]} !== 5'b1_0111) begin n_errors++; $display("FAIL after_hs: got rdy %b cnt %0d exp 1 7", req_rdy[0], cnt[0]); end
        n_checks++; if (rsp_id[0] !== 4'd1) begin n_errors++; $display("FAIL after_hs_id: got %h exp 1", rsp_id[0]); end
        tick();
        req_vld = 1'b0;
        n_checks++; if ({req_rdy[0], cnt[0]} !== 5'b0_1000) begin n_errors++; $display("FAIL ninth_accept: got rdy %b cnt %0d exp 0 8", req_rdy[0], cnt[0]); end
        rsp_rdy = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            n_checks++; if ({rsp_vld[0], rsp_id[0]} !== {1'b1, 4'(e)}) begin n_errors++; $display("FAIL stream_%0d: got vld %b id %h exp 1 %0d", e, rsp_vld[0], rsp_id[0], e); end
            tick();
        end
        n_checks++; if ({rsp_vld[0], cnt[0]} !== 5'b0_0000) begin n_errors++; $display("FAIL stream_drain: got vld %b cnt %0d exp 0 0", rsp_vld[0], cnt[0]); end
    endtask

    task automatic test_order();
        logic [3:0] seen1[$];
        logic [3:0] seen2[$];
        do_reset();
        rsp_rdy = 1'b1; req_vld = 1'b1; req_pld = 32'h60; req_id = 4'd1;
        tick();
        req_pld = 32'h0; req_id = 4'd2;
        tick();
        req_vld = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (rsp_vld[1]) seen1.push_back(rsp_id[1]);
            if (rsp_vld[2]) seen2.push_back(rsp_id[2]);
        end
        while (seen1.size() < 2) seen1.push_back(4'hF);
        while (seen2.size() < 2) seen2.push_back(4'hF);
        n_checks++; if ({seen1[0], seen1[1]} !== 8'h21) begin n_errors++; $display("FAIL ooo_order: got %h %h exp 2 1", seen1[0], seen1[1]); end
        n_checks++; if ({seen2[0], seen2[1]} !== 8'h12) begin n_errors++; $display("FAIL inorder_order: got %h %h exp 1 2", seen2[0], seen2[1]); end
    endtask

    task automatic test_dup();
        int cyc;
        do_reset();
        rsp_rdy = 1'b1; req_vld = 1'b1; req_pld = 32'h100; req_id = 4'd5;
        tick();
        n_checks++; if (err_dup[0] !== 1'b0) begin n_errors++; $display("FAIL dup_early: got %b exp 0", err_dup[0]); end
        req_pld = 32'h120;
        tick();
        req_vld = 1'b0;
        n_checks++; if (err_dup[0] !== 1'b1) begin n_errors++; $display("FAIL dup_set: got %b exp 1", err_dup[0]); end
        wait_vld(0, 20, cyc);
        n_checks++; if ({rsp_id[0], rsp_pld[0]} !== {4'd5, rep(32'h100)}) begin n_errors++; $display("FAIL dup_first: got id %h pld %h", rsp_id[0], rsp_pld[0]); end
        wait_vld(0, 20, cyc);
        n_checks++; if ({rsp_id[0], rsp_pld[0]} !== {4'd5, rep(32'h120)}) begin n_errors++; $display("FAIL dup_second: got id %h pld %h", rsp_id[0], rsp_pld[0]); end
        tick();
        n_checks++; if ({err_dup[0], cnt[0]} !== 5'b1_0000) begin n_errors++; $display("FAIL dup_sticky: got err %b cnt %0d exp 1 0", err_dup[0], cnt[0]); end
    endtask

    task automatic test_timeout();
        int cyc;
        logic [255:0] held_pld;
        logic [3:0]   held_id;
        logic         stable;
        logic         saw;
        do_reset();
        n_checks++; if (err_dup[0] !== 1'b0) begin n_errors++; $display("FAIL dup_cleared: got %b exp 0", err_dup[0]); end
        rsp_rdy = 1'b0; req_vld = 1'b1; req_pld = 32'h40; req_id = 4'd7;
        tick();
        req_pld = 32'h60; req_id = 4'd8;
        tick();
        req_vld = 1'b0;
        wait_vld(0, 20, cyc);
        n_checks++; if (cyc < 0) begin n_errors++; $display("FAIL to_rsp_seen: got timeout exp response"); end
        held_pld = rsp_pld[0]; held_id = rsp_id[0];
        n_checks++; if ({held_id, held_pld} !== {4'd7, rep(32'h40)}) begin n_errors++; $display("FAIL to_head: got id %h pld %h", held_id, held_pld); end
        stable = 1'b1;
        for (int c = 0; c < TIMEOUT - 2; c++) begin
            tick();
            if (rsp_pld[0] !== held_pld || rsp_id[0] !== held_id || rsp_vld[0] !== 1'b1) stable = 1'b0;
        end
        n_checks++; if (err_to[0] !== 1'b0) begin n_errors++; $display("FAIL to_early: got %b exp 0", err_to[0]); end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_pld[0] !== held_pld || rsp_id[0] !== held_id || rsp_vld[0] !== 1'b1) stable = 1'b0;
        end
        n_checks++; if (err_to[0] !== 1'b1) begin n_errors++; $display("FAIL to_set: got %b exp 1", err_to[0]); end
        n_checks++; if (stable !== 1'b1) begin n_errors++; $display("FAIL to_stable: got %b exp 1", stable); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({rsp_vld[0], rsp_id[0]} !== 5'b0_0000) begin n_errors++; $display("FAIL mid_rst_rsp: got vld %b id %h exp 0 0", rsp_vld[0], rsp_id[0]); end
        n_checks++; if (rsp_pld[0] !== '0) begin n_errors++; $display("FAIL mid_rst_pld: got %h exp 0", rsp_pld[0]); end
        n_checks++; if ({req_rdy[0], evict_rdy[0], cnt[0]} !== 6'b0) begin n_errors++; $display("FAIL mid_rst_ctl: got rdy %b ev %b cnt %0d exp 0 0 0", req_rdy[0], evict_rdy[0], cnt[0]); end
        n_checks++; if ({err_dup[0], err_to[0]} !== 2'b00) begin n_errors++; $display("FAIL mid_rst_errs: got %b%b exp 00", err_dup[0], err_to[0]); end
        rsp_rdy = 1'b1;
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (rsp_vld[0] !== 1'b0) saw = 1'b1;
        end
        n_checks++; if ({saw, cnt[0]} !== 5'b0_0000) begin n_errors++; $display("FAIL post_rst_quiet: got saw %b cnt %0d exp 0 0", saw, cnt[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_evict();
        test_back_to_back();
        test_order();
        test_dup();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
